sar_adc_ctrl: RTL

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_sample_timer.sv | 30 +++
 rtl/sar_adc_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// SAR ADC controller shared types: FSM state
// encoding and default parameter constants.
package sar_pkg;

  localparam int SAR_WIDTH         = 8;
  localparam int SAR_SAMPLE_CYCLES = 8;
  localparam int SAR_NUM_CH        = 4;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT
  } sar_state_t;

endpackage

// File: rtl/sar_sample_timer.sv
// Sample-phase timer. load clears, en counts,
// done flags the last sample clock.
module sar_sample_timer #(
  parameter int SAMPLE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [7:0] LAST =
    8'(SAMPLE_CYCLES - 1);

  logic [7:0] count;

  assign done = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sample/hold, binary search
// over trial codes, multi-channel auto-scan.
// Ports: clk, reset, start, continuous, cmp_in
// in; sh, ch_sel, trial, data, data_ch, eoc, busy
// out.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int NUM_CH        = SAR_NUM_CH,
  localparam int CW =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             cmp_in,
  output logic             sh,
  output logic [CW-1:0]    ch_sel,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    data_ch,
  output logic             eoc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MSB =
    {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state;
  sar_state_t       state_nxt;
  logic [WIDTH-1:0] bp;
  logic [WIDTH-1:0] decided;
  logic [CW-1:0]    ch_nxt;
  logic             t_load;
  logic             t_en;
  logic             t_done;
  logic             to_conv;

  sar_sample_timer #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (t_load),
    .en   (t_en),
    .done (t_done)
  );

  assign sh   = (state != CONVERT);
  assign busy = (state != IDLE);

  assign decided = cmp_in ? trial
                          : (trial & ~bp);

  assign ch_nxt =
    (ch_sel == CW'(NUM_CH - 1)) ? '0
                                : ch_sel + 1'b1;

  // An auto-restart enters SAMPLE during the eoc
  // cycle; that cycle stands in for the start
  // request, so the timer holds while eoc is up.
  assign to_conv = (state == SAMPLE) &&
                   t_done && !eoc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SAMPLE;
          t_load    = 1'b1;
        end
      end
      SAMPLE: begin
        t_en = !eoc;
        if (to_conv) begin
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (bp[0]) begin
          if (continuous) begin
            state_nxt = SAMPLE;
            t_load    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trial   <= '0;
      bp      <= '0;
      data    <= '0;
      data_ch <= '0;
      ch_sel  <= '0;
      eoc     <= 1'b0;
    end else begin
      eoc <= 1'b0;
      if (to_conv) begin
        trial <= MSB;
        bp    <= MSB;
      end else if (state == CONVERT) begin
        trial <= decided | (bp >> 1);
        bp    <= bp >> 1;
        if (bp[0]) begin
          data    <= decided;
          data_ch <= ch_sel;
          eoc     <= 1'b1;
          ch_sel  <= ch_nxt;
        end
      end
    end
  end

endmodule
